// File: rtl/led_slot_chaser_pkg.sv
// Shared constants and helpers for the time-slotted LED chaser.
// Period defaults cover simulation (short) and the 50 MHz board build (1 s).
package led_pkg;

    localparam int LED_PERIOD_SIM = 400;
    localparam int LED_PERIOD_HW  = 50_000_000;
    localparam int LED_NUM_SLOTS  = 4;
    localparam int LED_NUM_LEDS   = 3;

    // A one-cycle period still needs a 1-bit counter.
    function automatic int led_cnt_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/led_slot_chaser_if.sv
// LED drive bundle between the chaser (master) and the board pins or a bench (slave).
interface led_slot_chaser_if #(
    parameter int NUM_LEDS = 3
);

    logic [NUM_LEDS-1:0] LED_Out;

    modport master (output LED_Out);
    modport slave  (input  LED_Out);

endinterface

// File: rtl/led_slot_chaser_slot_decode.sv
// One LED: a registered window compare of the shared period count.
// The output is high while the previous-cycle count lies in [SLOT_INDEX*SLOT_LEN, (SLOT_INDEX+1)*SLOT_LEN).
module led_slot_decode #(
    parameter int SLOT_INDEX = 0,
    parameter int SLOT_LEN   = 100,
    parameter int CNT_W      = 9
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [CNT_W-1:0] count,
    output logic             LED_Out
);

    localparam int LO = SLOT_INDEX * SLOT_LEN;
    localparam int HI = LO + SLOT_LEN;

    logic [31:0] w_count_ext;
    logic        w_in_slot;
    logic        r_led;

    assign w_count_ext = 32'(count);

    // Slot 0 has no lower bound; leaving it out avoids an always-true compare.
    generate
        if (SLOT_INDEX == 0) begin : g_first_slot
            assign w_in_slot = (w_count_ext < 32'(HI));
        end else begin : g_later_slot
            assign w_in_slot = (w_count_ext >= 32'(LO)) && (w_count_ext < 32'(HI));
        end
    endgenerate

    // NOTE: state is written with <= so every flop samples pre-edge values, giving the one-cycle count-to-LED latency.
    always_ff @(posedge CLK) begin
        if (RST_n) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_in_slot;
        end
    end

    assign LED_Out = r_led;

endmodule

// File: rtl/led_slot_chaser.sv
// Time-slotted LED sequencer: one free-running period counter shared by all LEDs.
// RST_n is synchronous and active-high despite its name.
module led_slot_chaser
    import led_pkg::*;
#(
    parameter int PERIOD_CYCLES = LED_PERIOD_SIM,
    parameter int NUM_SLOTS     = LED_NUM_SLOTS,
    parameter int NUM_LEDS      = LED_NUM_LEDS
) (
    input  logic              CLK,
    input  logic              RST_n,
    led_slot_chaser_if.master led_bus
);

    localparam int SLOT_LEN = PERIOD_CYCLES / NUM_SLOTS;
    localparam int CNT_W    = led_cnt_width(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

    generate
        if (PERIOD_CYCLES % NUM_SLOTS != 0) begin : g_bad_div
            $fatal(1, "PERIOD_CYCLES must be a multiple of NUM_SLOTS");
        end
        if (NUM_LEDS > NUM_SLOTS) begin : g_bad_leds
            $fatal(1, "NUM_LEDS must not exceed NUM_SLOTS");
        end
        if (PERIOD_CYCLES < NUM_SLOTS) begin : g_bad_period
            $fatal(1, "PERIOD_CYCLES must be at least NUM_SLOTS");
        end
    endgenerate

    logic [CNT_W-1:0]    r_count;
    logic [NUM_LEDS-1:0] w_led;

    always_ff @(posedge CLK) begin
        if (RST_n) begin
            r_count <= '0;
        end else if (r_count == CNT_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    generate
        for (genvar i = 0; i < NUM_LEDS; i++) begin : g_slot
            led_slot_decode #(
                .SLOT_INDEX (i),
                .SLOT_LEN   (SLOT_LEN),
                .CNT_W      (CNT_W)
            ) u_decode (
                .CLK     (CLK),
                .RST_n   (RST_n),
                .count   (r_count),
                .LED_Out (w_led[i])
            );
        end
    endgenerate

    assign led_bus.LED_Out = w_led;

endmodule

// File: tb/tb_led_slot_chaser.sv
// Directed bench: default 400-cycle chaser plus a 12-cycle override instance sharing clock and reset.
// Expected LED patterns come from the slot timing table, computed per edge index.
module tb_led_slot_chaser;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    led_slot_chaser_if #(.NUM_LEDS(3)) u_bus ();
    led_slot_chaser_if #(.NUM_LEDS(3)) u_bus_s ();

    led_slot_chaser #(
        .PERIOD_CYCLES (400),
        .NUM_SLOTS     (4),
        .NUM_LEDS      (3)
    ) dut (
        .CLK     (clk),
        .RST_n   (rst),
        .led_bus (u_bus.master)
    );

    led_slot_chaser #(
        .PERIOD_CYCLES (12),
        .NUM_SLOTS     (4),
        .NUM_LEDS      (3)
    ) dut_s (
        .CLK     (clk),
        .RST_n   (rst),
        .led_bus (u_bus_s.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected LED pattern after edge k (k >= 1) for a period split into 4 slots.
    function automatic logic [2:0] exp_led(input int k, input int period);
        int m;
        int slot;
        m    = (k - 1) % period;
        slot = m / (period / 4);
        case (slot)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    initial begin
        logic [2:0] prev;
        int         led0_rises;
        int         wraps;
        int         prev_cnt;
        int         m;

        total = 0;
        bad   = 0;
        rst   = 1'b1;

        // Reset hold
        for (int c = 0; c < 10; c++) begin
            step();
            check("rst_led", 32'(u_bus.LED_Out), 32'd0);
            check("rst_cnt", 32'(dut.r_count), 32'd0);
            check("rst_led_s", 32'(u_bus_s.LED_Out), 32'd0);
        end

        // Free run for 1000 edges from release
        rst        = 1'b0;
        prev       = 3'b000;
        led0_rises = 0;
        wraps      = 0;
        prev_cnt   = 0;
        for (int k = 1; k <= 1000; k++) begin
            step();
            check("seq_led", 32'(u_bus.LED_Out), 32'(exp_led(k, 400)));
            check("seq_cnt", 32'(dut.r_count), 32'(k % 400));
            check("onehot", 32'($countones(u_bus.LED_Out) <= 1), 32'd1);
            check("ovr_led", 32'(u_bus_s.LED_Out), 32'(exp_led(k, 12)));
            if (u_bus.LED_Out !== prev) begin
                m = (k - 1) % 400;
                check("edge_pos", 32'(m == 0 || m == 100 || m == 200 || m == 300), 32'd1);
            end
            if (u_bus.LED_Out[0] && !prev[0]) led0_rises++;
            if (prev_cnt == 399 && int'(dut.r_count) == 0) wraps++;
            prev     = u_bus.LED_Out;
            prev_cnt = int'(dut.r_count);
        end
        check("led0_rises", 32'(led0_rises), 32'd3);
        check("wraps", 32'(wraps), 32'd2);

        // Mid-operation reset at edge 150
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 149; k++) step();
        check("pre_mid_led", 32'(u_bus.LED_Out), 32'b010);
        rst = 1'b1;
        step();
        check("mid_rst_led", 32'(u_bus.LED_Out), 32'd0);
        check("mid_rst_cnt", 32'(dut.r_count), 32'd0);
        check("mid_rst_led_s", 32'(u_bus_s.LED_Out), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 101; k++) begin
            step();
            check("post_rst_led", 32'(u_bus.LED_Out), 32'(exp_led(k, 400)));
            check("post_rst_led_s", 32'(u_bus_s.LED_Out), 32'(exp_led(k, 12)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
